rv32i_pc_fetch_queue: RTL and testbench
=======================================

// Module: rv32i_pc_fetch_queue
// PURPOSE
//  Program counter generator and instruction prefetch queue. Sits directly upstream of the fetch stage.
//  Issues sequential word fetches to instruction memory over a req/ack handshake and buffers returned
//  words with their PC in a small FIFO. Presents the head entry to the fetch stage and honours its stall.
//  On redirect (branch/jump/trap) it flushes the FIFO, drops any in-flight word and refetches from the new PC.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC of the first fetch after reset
//  DEPTH     4              FIFO entries; power of two, >= 2
// PORTS
//  i_clk         in   1   clock; all state updates on the rising edge
//  i_rst         in   1   asynchronous reset, active-high
//  o_imem_req    out  1   fetch request; held until acknowledged
//  o_imem_addr   out  32  fetch word address; bits [1:0] always 2'b00
//  i_imem_ack    in   1   request accepted; i_imem_data valid this cycle
//  i_imem_data   in   32  returned instruction word
//  i_change_pc   in   1   redirect strobe (1 cycle)
//  i_new_pc      in   32  redirect target
//  i_stall       in   1   fetch stage cannot accept this cycle
//  o_valid       out  1   head entry valid (drives fetch-stage clock enable)
//  o_inst        out  32  head instruction word
//  o_pc          out  32  PC of head instruction
// BEHAVIOUR
//  Reset (async, immediate): o_imem_req=0, o_imem_addr=PC_RESET, o_valid=0, o_inst=0, o_pc=0, FIFO empty,
//    state=FETCH. Any in-flight memory transaction is abandoned; memory must tolerate this.
//  First rising edge after i_rst falls: o_imem_req=1, o_imem_addr=PC_RESET.
//  Handshake: at most one outstanding request. o_imem_req/o_imem_addr are registered and stay stable until a
//    cycle with req&&ack. i_imem_ack may be high in the first cycle req is high. i_imem_ack is ignored while req=0.
//  Pop: o_valid && !i_stall at the edge removes the head entry.
//  Push: req&&ack in state FETCH writes {addr, data} at the tail. o_valid rises the cycle after the ack (1-cycle latency).
//  Issue: after the ack edge, req stays high next cycle with addr+4 iff count_next < DEPTH; otherwise req=0
//    until a pop frees a slot. A free slot is therefore always reserved for the outstanding word.
//  Full: count==DEPTH means req=0 and no push. Empty: o_valid=0; o_inst/o_pc hold their last values.
//  Pointers wrap modulo DEPTH. PC arithmetic wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//  FSM states:
//    FETCH   : normal. On i_change_pc, FIFO flushed and pc<=i_new_pc&~3.
//              If req is pending without ack, go to DISCARD. If the ack arrives the same cycle as
//              i_change_pc, its data is dropped, stay in FETCH, and request i_new_pc the next cycle.
//    DISCARD : req held with the old address until ack; the acked word is dropped; go to FETCH and request
//              the latched target the next cycle. A further i_change_pc here updates the target only.
//  Simultaneous events: redirect beats pop and push. o_valid=0 the cycle after any i_change_pc.
//    Pop and push in the same cycle leave count unchanged.
// CONFIGURATION
//  RV32I_FETCH_MISALIGN_EN
//    defined    : i_change_pc with i_new_pc[1:0]!=0 sets output o_misaligned (1 bit, reset 0). Fetching halts
//                 (req=0 once any pending ack completes) until the next aligned i_change_pc, which clears it.
//    undefined  : o_misaligned port absent. i_new_pc[1:0] is silently forced to 2'b00.
// TESTING
//  1. Reset release, ack every cycle, i_stall=0 -> addrs 0,4,8,C on consecutive cycles; o_pc matches one cycle after each ack.
//  2. i_stall=1 held, ack always -> exactly DEPTH=4 words buffered, req drops to 0. Release stall -> 4 pops, fetch resumes at 0x10.
//  3. Ack delayed 3 cycles -> req/addr stable for all 3 cycles. Only one push, o_valid asserted 1 cycle after the ack.
//  4. Redirect to 0x200 while req@0x8 pending -> 0x8 word dropped when acked, FIFO empty, next req addr=0x200.
//  5. Redirect same cycle as ack of 0xC plus pop -> no push of 0xC, o_valid=0 next cycle, next req addr = target.
//  6. PC_RESET=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert i_rst mid-request -> outputs return to reset values immediately.
//  7. (MISALIGN_EN) redirect to 0x102 -> o_misaligned=1, no further req. Redirect to 0x100 -> cleared, req addr=0x100.

Source files
------------

// File: rtl/rv32i_pc_fetch_queue_if.sv
// Instruction-memory fetch bus: single-outstanding req/ack handshake with returned data.
interface rv32i_pc_fetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );
endinterface

// File: rtl/rv32i_pc_fetch_queue.sv
// PC generator and instruction prefetch queue feeding the fetch stage.
// Optional misaligned-redirect detection is enabled by defining RV32I_FETCH_MISALIGN_EN.
module rv32i_pc_fetch_queue #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rv32i_pc_fetch_queue_if.master imem,
  input  logic                   i_change_pc,
  input  logic [31:0]            i_new_pc,
  input  logic                   i_stall,
`ifdef RV32I_FETCH_MISALIGN_EN
  output logic                   o_misaligned,
`endif
  output logic                   o_valid,
  output logic [31:0]            o_inst,
  output logic [31:0]            o_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StFetch, StDiscard} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       target_q, target_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [31:0]       pc_mem_q [DEPTH];
  logic [31:0]       pc_mem_d [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];
  logic [31:0]       inst_mem_d [DEPTH];
  logic [31:0]       hold_pc_q, hold_pc_d;
  logic [31:0]       hold_inst_q, hold_inst_d;

  logic              fire;
  logic              push;
  logic              pop;
  logic [31:0]       redirect_pc;
  logic              redirect_mis;
  logic              halt_q;
  logic              halt_next;

  assign fire        = req_q & imem.ack;
  assign redirect_pc = {i_new_pc[31:2], 2'b00};
  assign halt_next   = i_change_pc ? redirect_mis : halt_q;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign redirect_mis = |i_new_pc[1:0];
  assign o_misaligned = halt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_next;
    end
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^i_new_pc[1:0];
  assign redirect_mis  = 1'b0;
  assign halt_q        = 1'b0;
`endif

  assign imem.req  = req_q;
  assign imem.addr = addr_q;

  // Head outputs fall back to the last presented entry while the queue is empty.
  assign o_valid = (count_q != '0);
  assign o_inst  = o_valid ? inst_mem_q[rptr_q] : hold_inst_q;
  assign o_pc    = o_valid ? pc_mem_q[rptr_q]   : hold_pc_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    target_d    = target_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pc_mem_d    = pc_mem_q;
    inst_mem_d  = inst_mem_q;
    hold_pc_d   = o_pc;
    hold_inst_d = o_inst;
    push        = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (i_change_pc) begin
          count_d = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          if (req_q && !imem.ack) begin
            // The old word is still owed by memory; swallow it before refetching.
            state_d  = StDiscard;
            target_d = redirect_pc;
          end else begin
            req_d  = !halt_next;
            addr_d = redirect_pc;
          end
        end else begin
          push = fire;
          pop  = o_valid && !i_stall;
          if (push) begin
            pc_mem_d[wptr_q]   = addr_q;
            inst_mem_d[wptr_q] = imem.data;
            wptr_d             = wptr_q + PtrW'(1);
          end
          if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
          end
          if (push && !pop) begin
            count_d = count_q + CntW'(1);
          end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
          end
          // A new request is only issued while a slot is free for its word.
          if (fire || !req_q) begin
            req_d = (count_d != DepthCnt) && !halt_q;
            if (fire) begin
              addr_d = addr_q + 32'd4;
            end
          end
        end
      end

      StDiscard: begin
        if (i_change_pc) begin
          target_d = redirect_pc;
        end
        if (imem.ack) begin
          state_d = StFetch;
          req_d   = !halt_next;
          addr_d  = target_d;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StFetch;
      req_q       <= 1'b0;
      addr_q      <= {PC_RESET[31:2], 2'b00};
      target_q    <= {PC_RESET[31:2], 2'b00};
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      target_q    <= target_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      pc_mem_q    <= pc_mem_d;
      inst_mem_q  <= inst_mem_d;
    end
  end

endmodule

// File: tb/tb_rv32i_pc_fetch_queue.sv
// Directed bench for rv32i_pc_fetch_queue: default-reset instance plus a wrap-around PC_RESET instance.
module tb_rv32i_pc_fetch_queue;

  logic        clk;
  logic        rst0;
  logic        rst1;
  logic        chg;
  logic [31:0] npc;
  logic        stall0;
  logic        valid0;
  logic [31:0] inst0;
  logic [31:0] pc0;
  logic        valid1;
  logic [31:0] inst1;
  logic [31:0] pc1;
`ifdef RV32I_FETCH_MISALIGN_EN
  logic        mis0;
  logic        mis1;
`endif

  int checks = 0;
  int errors = 0;

  rv32i_pc_fetch_queue_if imem0 ();
  rv32i_pc_fetch_queue_if imem1 ();

  // Memory returns addr + 0x1000_0000 as the instruction word.
  assign imem0.data = imem0.addr + 32'h1000_0000;
  assign imem1.data = imem1.addr + 32'h1000_0000;

  rv32i_pc_fetch_queue #(
    .PC_RESET (32'h0000_0000),
    .DEPTH    (4)
  ) dut0 (
    .i_clk        (clk),
    .i_rst        (rst0),
    .imem         (imem0),
    .i_change_pc  (chg),
    .i_new_pc     (npc),
    .i_stall      (stall0),
`ifdef RV32I_FETCH_MISALIGN_EN
    .o_misaligned (mis0),
`endif
    .o_valid      (valid0),
    .o_inst       (inst0),
    .o_pc         (pc0)
  );

  rv32i_pc_fetch_queue #(
    .PC_RESET (32'hFFFF_FFF8),
    .DEPTH    (4)
  ) dut1 (
    .i_clk        (clk),
    .i_rst        (rst1),
    .imem         (imem1),
    .i_change_pc  (1'b0),
    .i_new_pc     (32'h0),
    .i_stall      (1'b0),
`ifdef RV32I_FETCH_MISALIGN_EN
    .o_misaligned (mis1),
`endif
    .o_valid      (valid1),
    .o_inst       (inst1),
    .o_pc         (pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    chg = 1'b0;
    npc = 32'h0;
    stall0 = 1'b0;
    imem0.ack = 1'b0;
    imem1.ack = 1'b0;
    cyc();
    chk("rst_req", 32'(imem0.req), 32'd0);
    chk("rst_addr", imem0.addr, 32'h0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_inst", inst0, 32'h0);
    chk("rst_pc", pc0, 32'h0);

    // Sequential fetch with ack every cycle
    rst0 = 1'b0;
    imem0.ack = 1'b1;
    cyc();
    chk("t1_req", 32'(imem0.req), 32'd1);
    chk("t1_addr0", imem0.addr, 32'h0);
    chk("t1_valid0", 32'(valid0), 32'd0);
    cyc();
    chk("t1_addr4", imem0.addr, 32'h4);
    chk("t1_valid1", 32'(valid0), 32'd1);
    chk("t1_pc0", pc0, 32'h0);
    chk("t1_inst0", inst0, 32'h1000_0000);
    cyc();
    chk("t1_addr8", imem0.addr, 32'h8);
    chk("t1_pc4", pc0, 32'h4);
    cyc();
    chk("t1_addrc", imem0.addr, 32'hC);
    chk("t1_pc8", pc0, 32'h8);
    chk("t1_inst8", inst0, 32'h1000_0008);

    // Stall fills the queue to DEPTH, then drains
    rst0 = 1'b1;
    cyc();
    rst0 = 1'b0;
    stall0 = 1'b1;
    repeat (5) cyc();
    chk("t2_req_full", 32'(imem0.req), 32'd0);
    chk("t2_addr_next", imem0.addr, 32'h10);
    chk("t2_head_pc", pc0, 32'h0);
    cyc();
    chk("t2_req_hold", 32'(imem0.req), 32'd0);
    chk("t2_head_inst", inst0, 32'h1000_0000);
    stall0 = 1'b0;
    cyc();
    chk("t2_req_resume", 32'(imem0.req), 32'd1);
    chk("t2_addr_resume", imem0.addr, 32'h10);
    chk("t2_pop1", pc0, 32'h4);
    cyc();
    chk("t2_pop2", pc0, 32'h8);
    cyc();
    chk("t2_pop3", pc0, 32'hC);
    cyc();
    chk("t2_new10", pc0, 32'h10);

    // Ack delayed three cycles
    rst0 = 1'b1;
    imem0.ack = 1'b0;
    cyc();
    rst0 = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_stable", 32'(imem0.req), 32'd1);
      chk("t3_addr_stable", imem0.addr, 32'h0);
      chk("t3_valid_low", 32'(valid0), 32'd0);
      if (i < 2) cyc();
    end
    imem0.ack = 1'b1;
    cyc();
    imem0.ack = 1'b0;
    chk("t3_valid_after", 32'(valid0), 32'd1);
    chk("t3_pc", pc0, 32'h0);
    chk("t3_addr4", imem0.addr, 32'h4);
    cyc();
    chk("t3_one_push", 32'(valid0), 32'd0);
    chk("t3_inst_hold", inst0, 32'h1000_0000);

    // Redirect while req@0x8 is pending
    imem0.ack = 1'b1;
    cyc();
    chk("t4_addr8", imem0.addr, 32'h8);
    chk("t4_pc4", pc0, 32'h4);
    imem0.ack = 1'b0;
    chg = 1'b1;
    npc = 32'h200;
    cyc();
    chg = 1'b0;
    chk("t4_flush", 32'(valid0), 32'd0);
    chk("t4_hold_addr", imem0.addr, 32'h8);
    chk("t4_hold_req", 32'(imem0.req), 32'd1);
    cyc();
    chk("t4_hold_addr2", imem0.addr, 32'h8);
    imem0.ack = 1'b1;
    cyc();
    chk("t4_dropped", 32'(valid0), 32'd0);
    chk("t4_target", imem0.addr, 32'h200);
    cyc();
    chk("t4_pc200", pc0, 32'h200);
    chk("t4_inst200", inst0, 32'h1000_0200);
    cyc();
    chk("t4_pc204", pc0, 32'h204);
    chk("t4_addr208", imem0.addr, 32'h208);

    // Redirect coinciding with ack and pop
    cyc();
    chk("t5_pc208", pc0, 32'h208);
    chk("t5_addr20c", imem0.addr, 32'h20C);
    chg = 1'b1;
    npc = 32'h300;
    cyc();
    chg = 1'b0;
    chk("t5_valid_low", 32'(valid0), 32'd0);
    chk("t5_target", imem0.addr, 32'h300);
    chk("t5_pc_hold", pc0, 32'h208);
    cyc();
    chk("t5_pc300", pc0, 32'h300);

`ifdef RV32I_FETCH_MISALIGN_EN
    chg = 1'b1;
    npc = 32'h102;
    cyc();
    chg = 1'b0;
    chk("t7_mis_set", 32'(mis0), 32'd1);
    chk("t7_req_off", 32'(imem0.req), 32'd0);
    chk("t7_valid_off", 32'(valid0), 32'd0);
    cyc();
    chk("t7_req_still_off", 32'(imem0.req), 32'd0);
    chg = 1'b1;
    npc = 32'h100;
    cyc();
    chg = 1'b0;
    chk("t7_mis_clr", 32'(mis0), 32'd0);
    chk("t7_req_on", 32'(imem0.req), 32'd1);
    chk("t7_addr100", imem0.addr, 32'h100);
`else
    chg = 1'b1;
    npc = 32'h402;
    cyc();
    chg = 1'b0;
    chk("t7_lsb_forced", imem0.addr, 32'h400);
    chk("t7_req_on", 32'(imem0.req), 32'd1);
    cyc();
    chk("t7_pc400", pc0, 32'h400);
`endif

    // Wrapping PC_RESET and asynchronous reset mid-request
    imem0.ack = 1'b0;
    rst1 = 1'b0;
    imem1.ack = 1'b1;
    cyc();
    chk("t6_addr_f8", imem1.addr, 32'hFFFF_FFF8);
    chk("t6_req", 32'(imem1.req), 32'd1);
    cyc();
    chk("t6_addr_fc", imem1.addr, 32'hFFFF_FFFC);
    chk("t6_pc_f8", pc1, 32'hFFFF_FFF8);
    chk("t6_inst_f8", inst1, 32'h0FFF_FFF8);
    cyc();
    chk("t6_addr_wrap", imem1.addr, 32'h0);
    chk("t6_pc_fc", pc1, 32'hFFFF_FFFC);
    #2;
    rst1 = 1'b1;
    #1;
    chk("t6_arst_req", 32'(imem1.req), 32'd0);
    chk("t6_arst_addr", imem1.addr, 32'hFFFF_FFF8);
    chk("t6_arst_valid", 32'(valid1), 32'd0);
    chk("t6_arst_pc", pc1, 32'h0);
    chk("t6_arst_inst", inst1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
